control_sequencer: RTL and testbench

//  Hardwired Moore control unit for the 3-bus-free single-bus datapath. Steps fetch/decode/execute
//  T-states from the current IR opcode and drives the register-file select strobes (Gra/Grb/Grc,
//  Rin/Rout/BAout) consumed by the register select/encode logic, plus all datapath/memory strobes.

---
 rtl/cpu_defs_pkg.sv | 52 +++++
 rtl/control_sequencer_if.sv | 31 +++
 rtl/op_classify.sv | 30 +++
 rtl/control_sequencer.sv | 121 ++++++++++++
 tb/tb_control_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// instruction classes, sequencer states and the strobe bundle.
package cpu_defs_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'h00;
  localparam logic [OPW-1:0] OP_ST   = 5'h02;
  localparam logic [OPW-1:0] OP_ADD  = 5'h03;
  localparam logic [OPW-1:0] OP_SUB  = 5'h04;
  localparam logic [OPW-1:0] OP_AND  = 5'h05;
  localparam logic [OPW-1:0] OP_OR   = 5'h06;
  localparam logic [OPW-1:0] OP_ADDI = 5'h0C;
  localparam logic [OPW-1:0] OP_ANDI = 5'h0D;
  localparam logic [OPW-1:0] OP_ORI  = 5'h0E;
  localparam logic [OPW-1:0] OP_BR   = 5'h12;
  localparam logic [OPW-1:0] OP_NOP  = 5'h1A;
  localparam logic [OPW-1:0] OP_HALT = 5'h1B;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [2:0] {
    CL_ALUR, CL_ALUI, CL_LD, CL_ST, CL_BR, CL_NOP, CL_HALT
  } op_class_e;

  typedef enum logic [4:0] {
    RESET_ST,
    FETCH0, FETCH1, FETCH2,
    ALUR_T3, ALUR_T4, ALUR_T5,
    ALUI_T3, ALUI_T4, ALUI_T5,
    LD_T3, LD_T4, LD_T5, LD_T6, LD_T7,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    BR_T3, BR_T4, BR_T5, BR_T6,
    HALT_ST
  } state_e;

  typedef struct packed {
    logic gra, grb, grc;
    logic rin, rout, baout;
    logic pcout, pcin, incpc;
    logic marin, mdrin, mdrout;
    logic read, write;
    logic irin, yin, zin, zlowout, cout, conin;
    logic run;
    logic [ALUW-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath: IR/condition/stop in,
// every register, memory and ALU strobe out.
interface control_sequencer_if;
  import cpu_defs_pkg::*;

  logic            stop;
  logic [31:0]     ir;
  logic            con_ff;
  logic            Gra, Grb, Grc;
  logic            Rin, Rout, BAout;
  logic            PCout, PCin, IncPC;
  logic            MARin, MDRin, MDRout;
  logic            Read, Write;
  logic            IRin, Yin, Zin, Zlowout, Cout, CONin;
  logic [ALUW-1:0] alu_op;
  logic            run;

  modport master (
    input  stop, ir, con_ff,
    output Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
           MARin, MDRin, MDRout, Read, Write,
           IRin, Yin, Zin, Zlowout, Cout, CONin, alu_op, run
  );

  modport slave (
    output stop, ir, con_ff,
    input  Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
           MARin, MDRin, MDRout, Read, Write,
           IRin, Yin, Zin, Zlowout, Cout, CONin, alu_op, run
  );
endinterface

// File: rtl/op_classify.sv
// Combinational opcode decoder: maps the IR opcode field to an execute class
// and the ALU function used by that class.
module op_classify
  import cpu_defs_pkg::*;
(
  input  logic [OPW-1:0]  i_opcode,
  output op_class_e       o_class,
  output logic [ALUW-1:0] o_alu_op
);

  always_comb begin
    o_class  = CL_NOP;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_ADD:  begin o_class = CL_ALUR; o_alu_op = ALU_ADD; end
      OP_SUB:  begin o_class = CL_ALUR; o_alu_op = ALU_SUB; end
      OP_AND:  begin o_class = CL_ALUR; o_alu_op = ALU_AND; end
      OP_OR:   begin o_class = CL_ALUR; o_alu_op = ALU_OR;  end
      OP_ADDI: begin o_class = CL_ALUI; o_alu_op = ALU_ADD; end
      OP_ANDI: begin o_class = CL_ALUI; o_alu_op = ALU_AND; end
      OP_ORI:  begin o_class = CL_ALUI; o_alu_op = ALU_OR;  end
      OP_LD:   o_class = CL_LD;
      OP_ST:   o_class = CL_ST;
      OP_BR:   o_class = CL_BR;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: steps fetch/decode/execute T-states and decodes
// the current state into the datapath strobe set.
module control_sequencer
  import cpu_defs_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  control_sequencer_if.master bus
);

  state_e          r_state, w_state_next;
  op_class_e       w_class;
  logic [ALUW-1:0] w_alu_op;
  ctrl_t           w_ctl;
  logic            w_unused_ir;

  // Only the opcode field steers control; operand fields go to the datapath.
  assign w_unused_ir = ^bus.ir[31-OPW:0];

  op_classify u_op_classify (
    .i_opcode (bus.ir[31:32-OPW]),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RESET_ST;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RESET_ST: w_state_next = FETCH0;
      FETCH0:   w_state_next = FETCH1;
      FETCH1:   w_state_next = FETCH2;
      FETCH2: begin
        case (w_class)
          CL_ALUR: w_state_next = ALUR_T3;
          CL_ALUI: w_state_next = ALUI_T3;
          CL_LD:   w_state_next = LD_T3;
          CL_ST:   w_state_next = ST_T3;
          CL_BR:   w_state_next = BR_T3;
          CL_HALT: w_state_next = HALT_ST;
          default: w_state_next = bus.stop ? HALT_ST : FETCH0;
        endcase
      end
      ALUR_T3: w_state_next = ALUR_T4;
      ALUR_T4: w_state_next = ALUR_T5;
      ALUI_T3: w_state_next = ALUI_T4;
      ALUI_T4: w_state_next = ALUI_T5;
      LD_T3:   w_state_next = LD_T4;
      LD_T4:   w_state_next = LD_T5;
      LD_T5:   w_state_next = LD_T6;
      LD_T6:   w_state_next = LD_T7;
      ST_T3:   w_state_next = ST_T4;
      ST_T4:   w_state_next = ST_T5;
      ST_T5:   w_state_next = ST_T6;
      ST_T6:   w_state_next = ST_T7;
      BR_T3:   w_state_next = BR_T4;
      BR_T4:   w_state_next = BR_T5;
      BR_T5:   w_state_next = BR_T6;
      ALUR_T5, ALUI_T5, LD_T7, ST_T7, BR_T6:
        w_state_next = bus.stop ? HALT_ST : FETCH0;
      HALT_ST: w_state_next = HALT_ST;
      default: w_state_next = RESET_ST;
    endcase
  end

  always_comb begin
    w_ctl        = '0;
    w_ctl.alu_op = ALU_ADD;
    w_ctl.run    = (r_state != RESET_ST) && (r_state != HALT_ST);
    case (r_state)
      FETCH0:  begin w_ctl.pcout = 1'b1; w_ctl.marin = 1'b1; w_ctl.incpc = 1'b1; w_ctl.zin = 1'b1; end
      FETCH1:  begin w_ctl.zlowout = 1'b1; w_ctl.pcin = 1'b1; w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1; end
      FETCH2:  begin w_ctl.mdrout = 1'b1; w_ctl.irin = 1'b1; end
      ALUR_T3, ALUI_T3: begin w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.yin = 1'b1; end
      ALUR_T4: begin w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.zin = 1'b1; w_ctl.alu_op = w_alu_op; end
      ALUI_T4: begin w_ctl.cout = 1'b1; w_ctl.zin = 1'b1; w_ctl.alu_op = w_alu_op; end
      ALUR_T5, ALUI_T5: begin w_ctl.zlowout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
      LD_T3, ST_T3: begin w_ctl.grb = 1'b1; w_ctl.baout = 1'b1; w_ctl.yin = 1'b1; end
      LD_T4, ST_T4: begin w_ctl.cout = 1'b1; w_ctl.zin = 1'b1; end
      LD_T5, ST_T5: begin w_ctl.zlowout = 1'b1; w_ctl.marin = 1'b1; end
      LD_T6:   begin w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1; end
      LD_T7:   begin w_ctl.mdrout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
      ST_T6:   begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdrin = 1'b1; end
      ST_T7:   w_ctl.write = 1'b1;
      BR_T3:   begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.conin = 1'b1; end
      BR_T4:   begin w_ctl.pcout = 1'b1; w_ctl.yin = 1'b1; end
      BR_T5:   begin w_ctl.cout = 1'b1; w_ctl.zin = 1'b1; end
      // The one Mealy term: the branch is taken only when the condition holds.
      BR_T6:   begin w_ctl.zlowout = 1'b1; w_ctl.pcin = bus.con_ff; end
      default: ;
    endcase
  end

  assign bus.Gra     = w_ctl.gra;
  assign bus.Grb     = w_ctl.grb;
  assign bus.Grc     = w_ctl.grc;
  assign bus.Rin     = w_ctl.rin;
  assign bus.Rout    = w_ctl.rout;
  assign bus.BAout   = w_ctl.baout;
  assign bus.PCout   = w_ctl.pcout;
  assign bus.PCin    = w_ctl.pcin;
  assign bus.IncPC   = w_ctl.incpc;
  assign bus.MARin   = w_ctl.marin;
  assign bus.MDRin   = w_ctl.mdrin;
  assign bus.MDRout  = w_ctl.mdrout;
  assign bus.Read    = w_ctl.read;
  assign bus.Write   = w_ctl.write;
  assign bus.IRin    = w_ctl.irin;
  assign bus.Yin     = w_ctl.yin;
  assign bus.Zin     = w_ctl.zin;
  assign bus.Zlowout = w_ctl.zlowout;
  assign bus.Cout    = w_ctl.cout;
  assign bus.CONin   = w_ctl.conin;
  assign bus.alu_op  = w_ctl.alu_op;
  assign bus.run     = w_ctl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: one row per clock of
// expected strobes, plus hand sequences for reset abort and stop-to-halt.
module tb_control_sequencer;

  localparam logic [19:0] S_GRA   = 20'h80000, S_GRB   = 20'h40000, S_GRC    = 20'h20000;
  localparam logic [19:0] S_RIN   = 20'h10000, S_ROUT  = 20'h08000, S_BAOUT  = 20'h04000;
  localparam logic [19:0] S_PCOUT = 20'h02000, S_PCIN  = 20'h01000, S_INCPC  = 20'h00800;
  localparam logic [19:0] S_MARIN = 20'h00400, S_MDRIN = 20'h00200, S_MDROUT = 20'h00100;
  localparam logic [19:0] S_READ  = 20'h00080, S_WRITE = 20'h00040, S_IRIN   = 20'h00020;
  localparam logic [19:0] S_YIN   = 20'h00010, S_ZIN   = 20'h00008, S_ZLOW   = 20'h00004;
  localparam logic [19:0] S_COUT  = 20'h00002, S_CONIN = 20'h00001;

  localparam logic [31:0] IR_ADD  = 32'h18948000;
  localparam logic [31:0] IR_ANDI = 32'h68000000;
  localparam logic [31:0] IR_ST   = 32'h10800000;
  localparam logic [31:0] IR_LD   = 32'h00000000;
  localparam logic [31:0] IR_BR   = 32'h90000000;
  localparam logic [31:0] IR_UNDF = 32'hF8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_ORI  = 32'h70000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  typedef struct {
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [19:0] exp_s;
    logic [3:0]  exp_alu;
    logic        exp_run;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] strobes();
    return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
            bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
            bus.Read, bus.Write, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
            bus.Cout, bus.CONin};
  endfunction

  task automatic check(input string name, input int step, input logic [19:0] es,
                       input logic [3:0] ea, input logic er);
    logic [19:0] s;
    s = strobes();
    checks++;
    if (s !== es || bus.alu_op !== ea || bus.run !== er) begin
      errors++;
      $display("FAIL %s step %0d: got strobes=%05h alu_op=%0d run=%0b, want strobes=%05h alu_op=%0d run=%0b",
               name, step, s, bus.alu_op, bus.run, es, ea, er);
    end else begin
      $display("ok   %s step %0d: strobes=%05h alu_op=%0d run=%0b", name, step, s, bus.alu_op, bus.run);
    end
  endtask

  task automatic add(input logic [31:0] ir, input logic cf, input logic st,
                     input logic [19:0] s, input logic [3:0] alu, input logic run);
    vec_t v;
    v.ir = ir; v.con_ff = cf; v.stop = st; v.exp_s = s; v.exp_alu = alu; v.exp_run = run;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input logic cf);
    add(ir, cf, 1'b0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 1'b1);
    add(ir, cf, 1'b0, S_ZLOW | S_PCIN | S_READ | S_MDRIN, 4'd0, 1'b1);
    add(ir, cf, 1'b0, S_MDROUT | S_IRIN, 4'd0, 1'b1);
  endtask

  task automatic add_br(input logic cf);
    add_fetch(IR_BR, cf);
    add(IR_BR, cf, 1'b0, S_GRA | S_ROUT | S_CONIN, 4'd0, 1'b1);
    add(IR_BR, cf, 1'b0, S_PCOUT | S_YIN, 4'd0, 1'b1);
    add(IR_BR, cf, 1'b0, S_COUT | S_ZIN, 4'd0, 1'b1);
    add(IR_BR, cf, 1'b0, S_ZLOW | (cf ? S_PCIN : 20'h0), 4'd0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stop = 1'b0;
    bus.ir = IR_ADD;
    bus.con_ff = 1'b0;

    add(IR_ADD, 1'b0, 1'b0, 20'h0, 4'd0, 1'b0);                  // RESET_ST
    add_fetch(IR_ADD, 1'b0);
    add(IR_ADD, 1'b0, 1'b0, S_GRB | S_ROUT | S_YIN, 4'd0, 1'b1);
    add(IR_ADD, 1'b0, 1'b0, S_GRC | S_ROUT | S_ZIN, 4'd0, 1'b1);
    add(IR_ADD, 1'b0, 1'b0, S_ZLOW | S_GRA | S_RIN, 4'd0, 1'b1);
    add_fetch(IR_ANDI, 1'b0);
    add(IR_ANDI, 1'b0, 1'b0, S_GRB | S_ROUT | S_YIN, 4'd0, 1'b1);
    add(IR_ANDI, 1'b0, 1'b0, S_COUT | S_ZIN, 4'd2, 1'b1);
    add(IR_ANDI, 1'b0, 1'b0, S_ZLOW | S_GRA | S_RIN, 4'd0, 1'b1);
    add_fetch(IR_ST, 1'b0);
    add(IR_ST, 1'b0, 1'b0, S_GRB | S_BAOUT | S_YIN, 4'd0, 1'b1);
    add(IR_ST, 1'b0, 1'b0, S_COUT | S_ZIN, 4'd0, 1'b1);
    add(IR_ST, 1'b0, 1'b0, S_ZLOW | S_MARIN, 4'd0, 1'b1);
    add(IR_ST, 1'b0, 1'b0, S_GRA | S_ROUT | S_MDRIN, 4'd0, 1'b1);
    add(IR_ST, 1'b0, 1'b0, S_WRITE, 4'd0, 1'b1);
    add_fetch(IR_LD, 1'b0);
    add(IR_LD, 1'b0, 1'b0, S_GRB | S_BAOUT | S_YIN, 4'd0, 1'b1);
    add(IR_LD, 1'b0, 1'b0, S_COUT | S_ZIN, 4'd0, 1'b1);
    add(IR_LD, 1'b0, 1'b0, S_ZLOW | S_MARIN, 4'd0, 1'b1);
    add(IR_LD, 1'b0, 1'b0, S_READ | S_MDRIN, 4'd0, 1'b1);
    add(IR_LD, 1'b0, 1'b0, S_MDROUT | S_GRA | S_RIN, 4'd0, 1'b1);
    add_br(1'b0);
    add_br(1'b1);
    add_fetch(IR_UNDF, 1'b0);
    add_fetch(IR_NOP, 1'b0);
    add_fetch(IR_ORI, 1'b0);
    add(IR_ORI, 1'b0, 1'b1, S_GRB | S_ROUT | S_YIN, 4'd0, 1'b1); // stop pulse ignored mid-instruction
    add(IR_ORI, 1'b0, 1'b0, S_COUT | S_ZIN, 4'd3, 1'b1);
    add(IR_ORI, 1'b0, 1'b0, S_ZLOW | S_GRA | S_RIN, 4'd0, 1'b1);
    add_fetch(IR_HALT, 1'b0);
    add(IR_HALT, 1'b0, 1'b0, 20'h0, 4'd0, 1'b0);
    add(IR_ADD, 1'b0, 1'b0, 20'h0, 4'd0, 1'b0);
    add(IR_ADD, 1'b0, 1'b1, 20'h0, 4'd0, 1'b0);

    repeat (2) @(negedge clock);
    #1 check("reset_hold", 0, 20'h0, 4'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.ir = vecs[i].ir;
      bus.con_ff = vecs[i].con_ff;
      bus.stop = vecs[i].stop;
      #1 check("table", i, vecs[i].exp_s, vecs[i].exp_alu, vecs[i].exp_run);
      @(negedge clock);
    end

    // Reset aborting LD in T6
    bus.stop = 1'b0;
    bus.ir = IR_LD;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(negedge clock);
    #1 check("ld_t6_before_abort", 0, S_READ | S_MDRIN, 4'd0, 1'b1);
    #1 reset = 1'b1;
    #1 check("ld_t6_async_abort", 1, 20'h0, 4'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("reset_st_after_abort", 2, 20'h0, 4'd0, 1'b0);
    @(negedge clock);
    #1 check("fetch0_after_abort", 3, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, 1'b1);

    // stop held from fetch: ignored until ADD's last T-state, then halt
    bus.ir = IR_ADD;
    bus.stop = 1'b1;
    repeat (3) @(negedge clock);
    #1 check("stop_ignored_t3", 0, S_GRB | S_ROUT | S_YIN, 4'd0, 1'b1);
    repeat (2) @(negedge clock);
    #1 check("stop_boundary_t5", 1, S_ZLOW | S_GRA | S_RIN, 4'd0, 1'b1);
    @(negedge clock);
    #1 check("stop_enters_halt", 2, 20'h0, 4'd0, 1'b0);
    bus.stop = 1'b0;
    repeat (2) @(negedge clock);
    #1 check("halt_held", 3, 20'h0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
